// File: rtl/dmem_port_arbiter_pkg.sv
// Shared data-memory constants: address/data widths, access size encodings
// and the arbiter defaults.
package dmem_port_arbiter_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W_DEF      = 4;

  // True when a CNT_W-bit counter can hold max and max is in its legal range.
  function automatic bit starve_cfg_ok(input int cnt_w, input int max);
    return (max >= 1) && (max <= 15) && ((64'd1 << cnt_w) > 64'(max));
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating starvation counter: clr has priority over inc, holds at MAX.
// Latency: count updates on the clock edge; at_max is combinational from the count.
module dmem_port_arbiter_starve_counter #(
  parameter int CNT_W = 4,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt >= CNT_W'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-way arbiter for the single data-memory port: loads win unless a store has been starved.
// Grants are combinational (stores write in the grant cycle); load data returns registered one cycle later.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_LEN,
  parameter int DATA_W     = DATA_LEN,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              st_gnt,
  input  logic              kill,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [1:0]        mem_rsize,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wsize,
  output logic              mem_we
);

  if (!starve_cfg_ok(CNT_W, STARVE_MAX)) begin : g_bad_cfg
    $error("dmem_port_arbiter: STARVE_MAX must be 1..15 and fit in CNT_W bits");
  end

  logic             starve_hit;
  logic             force_st;
  logic             st_win;
  logic [CNT_W-1:0] starve_cnt;

  dmem_port_arbiter_starve_counter #(
    .CNT_W (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (st_req && !st_gnt),
    .clr    (st_gnt || !st_req),
    .cnt    (starve_cnt),
    .at_max (starve_hit)
  );

  assign force_st = st_req && starve_hit;
  assign st_win   = st_req && (!ld_req || force_st);

  // Reset masks both grants so nothing reaches the memory while state is clearing.
  assign st_gnt = st_win && !reset;
  assign ld_gnt = ld_req && !st_win && !reset;

  assign mem_we    = st_gnt;
  assign mem_waddr = st_addr;
  assign mem_wdata = st_data;
  assign mem_wsize = st_size;
  assign mem_raddr = ld_addr;
  assign mem_rsize = ld_size;

  // A killed grant is consumed but its data is squashed along with the valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
    end else begin
      ld_rvalid <= ld_gnt && !kill;
      if (ld_gnt && !kill) begin
        ld_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a random phase, with a
// load-data scoreboard filled at grant and drained when the response is due.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, st_req, kill;
  logic [31:0] ld_addr, st_addr, st_data;
  logic [1:0]  ld_size, st_size;
  logic        ld_gnt, st_gnt, ld_rvalid, mem_we;
  logic [31:0] ld_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [1:0]  mem_rsize, mem_wsize;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          m_cnt;
  bit          m_rv, m_ld, m_st;
  logic [31:0] m_rdata;
  int          nl;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_gnt(st_gnt), .kill(kill),
    .mem_raddr(mem_raddr), .mem_rsize(mem_rsize), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wsize(mem_wsize),
    .mem_we(mem_we)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_rv    = 0;
    m_rdata = '0;
    exp_q.delete();
  endtask

  // One clock: check everything at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit force_st, st_w;
    logic [31:0] e;
    @(negedge clk);
    force_st = st_req && (m_cnt >= SMAX);
    st_w     = st_req && (!ld_req || force_st);
    m_st     = !reset && st_w;
    m_ld     = !reset && ld_req && !st_w;
    check_eq("ld_gnt", 32'(ld_gnt), 32'(m_ld));
    check_eq("st_gnt", 32'(st_gnt), 32'(m_st));
    check_eq("mem_we", 32'(mem_we), 32'(m_st));
    check_eq("mem_raddr", mem_raddr, ld_addr);
    check_eq("mem_rsize", 32'(mem_rsize), 32'(ld_size));
    check_eq("starve_cnt", 32'(dut.starve_cnt), 32'(m_cnt));
    check_eq("ld_rvalid", 32'(ld_rvalid), 32'(m_rv));
    if (m_st) begin
      check_eq("mem_waddr", mem_waddr, st_addr);
      check_eq("mem_wdata", mem_wdata, st_data);
      check_eq("mem_wsize", 32'(mem_wsize), 32'(st_size));
    end
    if (m_rv) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ld_rdata", ld_rdata, e);
        m_rdata = e;
      end
    end else begin
      check_eq("ld_rdata_hold", ld_rdata, m_rdata);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_rv = m_ld && !kill;
      if (m_rv) exp_q.push_back(mem_rdata);
      if (m_st || !st_req) m_cnt = 0;
      else if (m_cnt < SMAX) m_cnt++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ld_req = 1'b1; st_req = 1'b1; kill = 1'b0;
    ld_addr = 32'h40; ld_size = SZ_WORD; mem_rdata = 32'h0BAD_0001;
    st_addr = 32'h80; st_data = 32'h1234_5678; st_size = SZ_WORD;
    model_reset();

    // Reset held with both requests pending.
    repeat (2) cycle();
    check_eq("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    check_eq("rst_st_gnt", 32'(st_gnt), 32'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("first_ld", 32'(ld_gnt), 32'd1);
    check_eq("first_st", 32'(st_gnt), 32'd0);
    cycle();
    ld_req = 1'b0; st_req = 1'b0;
    repeat (2) cycle();

    // Single load with fixed data.
    ld_req = 1'b1; ld_addr = 32'h100; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    ld_req = 1'b0; mem_rdata = 32'h0;
    check_eq("load_rv_n1", 32'(ld_rvalid), 32'd1);
    check_eq("load_rd_n1", ld_rdata, 32'hDEAD_BEEF);
    cycle();
    check_eq("load_rv_n2", 32'(ld_rvalid), 32'd0);

    // Single store: same-cycle write, counter untouched.
    st_req = 1'b1; st_addr = 32'h8; st_data = 32'h5; st_size = SZ_BYTE;
    #1;
    check_eq("store_gnt", 32'(st_gnt), 32'd1);
    check_eq("store_we", 32'(mem_we), 32'd1);
    check_eq("store_waddr", mem_waddr, 32'h8);
    check_eq("store_wdata", mem_wdata, 32'h5);
    cycle();
    st_req = 1'b0;
    check_eq("store_cnt", 32'(dut.starve_cnt), 32'd0);
    cycle();

    // Both requests held: L,L,L,L,S repeating.
    ld_req = 1'b1; st_req = 1'b1; st_addr = 32'hA0; st_data = 32'hCAFE_0000; st_size = SZ_WORD;
    nl = 0;
    for (int i = 0; i < 10; i++) begin
      ld_addr = 32'h200 + 32'(4 * nl);
      mem_rdata = 32'hC0DE_0000 + 32'(nl);
      #1;
      check_eq("seq_st", 32'(st_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
      check_eq("seq_ld", 32'(ld_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
      cycle();
      if (m_ld) nl++;
    end
    ld_req = 1'b0; st_req = 1'b0;
    repeat (2) cycle();

    // Kill in the grant cycle drops the response and keeps the old data.
    ld_req = 1'b1; ld_addr = 32'h300; mem_rdata = 32'h1111_1111; kill = 1'b1;
    cycle();
    ld_req = 1'b0; kill = 1'b0;
    check_eq("kill_rv", 32'(ld_rvalid), 32'd0);
    check_eq("kill_rd", ld_rdata, 32'hC0DE_0007);
    ld_req = 1'b1; ld_addr = 32'h304; mem_rdata = 32'h2222_2222;
    cycle();
    ld_req = 1'b0;
    check_eq("after_kill_rv", 32'(ld_rvalid), 32'd1);
    check_eq("after_kill_rd", ld_rdata, 32'h2222_2222);
    cycle();

    // Async reset between edges right after a load grant, with a starved store.
    ld_req = 1'b1; st_req = 1'b1; ld_addr = 32'h400; mem_rdata = 32'h3333_3333;
    cycle();
    ld_req = 1'b0; st_req = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_eq("arst_rv", 32'(ld_rvalid), 32'd0);
    check_eq("arst_cnt", 32'(dut.starve_cnt), 32'd0);
    check_eq("arst_rd", ld_rdata, 32'd0);
    cycle();
    #2 reset = 1'b0;
    repeat (2) cycle();

    // Random traffic; requests held until granted.
    for (int i = 0; i < 80; i++) begin
      if (!ld_req || m_ld) begin
        ld_req  = ($urandom_range(0, 2) != 0);
        ld_addr = $urandom;
        ld_size = 2'($urandom_range(0, 2));
      end
      if (!st_req || m_st) begin
        st_req  = ($urandom_range(0, 1) != 0);
        st_addr = $urandom;
        st_data = $urandom;
        st_size = 2'($urandom_range(0, 2));
      end
      mem_rdata = $urandom;
      kill = ($urandom_range(0, 3) == 0);
      cycle();
    end
    ld_req = 1'b0; st_req = 1'b0; kill = 1'b0;
    repeat (2) cycle();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (draddr1/drdata1/dwaddr1/dwdata1/dwe1/size) of memory_nolatch between two requesters.
- Requester 0 is the load unit; requester 1 is the store-drain path.
- Loads win by default; a starvation counter forces a store grant after STARVE_MAX consecutive denied cycles.
- Read data is registered and returned one cycle after grant. A kill input squashes in-flight load responses on redirect.

Parameters:
- ADDR_W, `ADDR_LEN (32), address width.
- DATA_W, `DATA_LEN (32), data width.
- STARVE_MAX, 4, consecutive denied store cycles before the store is forced; legal range 1..15.
- CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_req  in  1  load request; must be held until ld_gnt is seen.
- ld_addr  in  ADDR_W  load byte address.
- ld_size  in  2  load size (0 byte, 1 half, 2 word).
- ld_gnt  out  1  load accepted this cycle (combinational).
- ld_rvalid  out  1  load data valid (registered).
- ld_rdata  out  DATA_W  load data (registered).
- st_req  in  1  store request; must be held until st_gnt is seen.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data.
- st_size  in  2  store size.
- st_gnt  out  1  store accepted and written this cycle (combinational).
- kill  in  1  squash any load response due next cycle.
- mem_raddr  out  ADDR_W  to draddr1.
- mem_rsize  out  2  to drsize1.
- mem_rdata  in  DATA_W  from drdata1 (same-cycle read).
- mem_waddr  out  ADDR_W  to dwaddr1.
- mem_wdata  out  DATA_W  to dwdata1.
- mem_wsize  out  2  to dwsize1.
- mem_we  out  1  to dwe1.

Behaviour:
- Reset (asynchronous, active-high) clears starve_cnt, ld_rvalid and ld_rdata to 0. While reset is high, ld_gnt, st_gnt and mem_we are forced to 0.
- Grant logic is combinational and grants at most one requester per cycle:
  - force_st = st_req && (starve_cnt >= STARVE_MAX).
  - st_gnt = st_req && (!ld_req || force_st).
  - ld_gnt = ld_req && !st_gnt.
- Memory drive:
  - mem_we = st_gnt; mem_waddr, mem_wdata and mem_wsize come from st_*.
  - mem_raddr and mem_rsize always follow ld_addr and ld_size.
  - mem_rdata is sampled only when ld_gnt is high.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when st_req && !st_gnt.
  - Clears to 0 when st_gnt, or when st_req is low.
- Load response, at the clock edge:
  - ld_rvalid <= ld_gnt && !kill.
  - ld_rdata <= mem_rdata when ld_gnt, otherwise it holds.
  - Load latency is exactly 1 cycle from grant to rvalid.
  - kill asserted in the grant cycle drops that response; the grant still counts as consumed.
  - ld_rvalid is a single-cycle pulse per grant.
- Back-to-back loads give one rvalid per cycle with no bubble. Stores have 0 latency: the write happens in the grant cycle.
- Simultaneous requests without starvation: the load wins and starve_cnt increments.
- Simultaneous requests at threshold: the store wins, starve_cnt resets, and the load waits one cycle.
- No ordering or forwarding between load and store to the same address. A load granted in the same cycle as a store is impossible. Ordering across cycles is the caller's responsibility.
- Reset asserted mid-operation: a pending rvalid is lost, the counter clears, and outputs recover on the first edge after release.

Decomposition:
- Size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) go into the shared constants.vh alongside ADDR_LEN and DATA_LEN, not locally.
- One natural sub-module: starve_counter (saturating counter with inc/clr and a threshold compare output).
- Grant and response logic stay in the top module.

Test Plan:
- Reset held with ld_req=1, st_req=1 -> ld_gnt=0, st_gnt=0, mem_we=0, ld_rvalid=0. After release, load granted first.
- Load only, ld_addr=0x100, mem_rdata=0xDEADBEEF -> ld_gnt=1 in cycle N; ld_rvalid=1 and ld_rdata=0xDEADBEEF in cycle N+1; ld_rvalid=0 in N+2.
- Store only, st_addr=0x8, st_data=0x5 -> st_gnt=1, mem_we=1, mem_waddr=0x8, mem_wdata=0x5 in the same cycle; starve_cnt stays 0.
- ld_req and st_req both held high continuously with STARVE_MAX=4 -> grant sequence L,L,L,L,S,L,L,L,L,S; starve_cnt reaches 4 then clears.
- Load granted with kill=1 in the grant cycle -> ld_rvalid=0 next cycle and ld_rdata unchanged. Next load without kill returns normally.
- Async reset pulse mid-cycle, between edges, right after a load grant -> ld_rvalid=0 immediately and no rvalid pulse after reset; starve_cnt=0.
